// File: rtl/core_seq_pkg.sv
// ----------------------------------------------------------------------------
// core_seq_pkg
// Shared definitions for the core sequencer:
//   - seq_state_e   : sequencer FSM state encoding
//   - OP_*          : RV32 opcode classes the sequencer cares about
//   - FUNCT7_MULDIV : funct7 value that selects the M-extension in R-type ops
//   - INSTR_EBREAK  : full EBREAK encoding (halts the sequencer)
// ----------------------------------------------------------------------------
package core_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_DECODE   = 3'd2,
      ST_EXEC     = 3'd3,
      ST_MUL_WAIT = 3'd4,
      ST_HALT     = 3'd5,
      ST_FAULT    = 3'd6
   } seq_state_e;

   localparam logic [6:0]  OP_RTYPE      = 7'b0110011;
   localparam logic [6:0]  OP_STORE      = 7'b0100011;
   localparam logic [6:0]  OP_BRANCH     = 7'b1100011;
   localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;
   localparam logic [31:0] INSTR_EBREAK  = 32'h00100073;

endpackage : core_seq_pkg

// File: rtl/seq_decode.sv
// ----------------------------------------------------------------------------
// seq_decode
// Purely combinational instruction classifier for the core sequencer.
//
// Ports:
//   instr_i     [31:0] in  : latched instruction word
//   is_mul_o           out : R-type with funct7 = MULDIV (uses the multiplier)
//   is_halt_o          out : instruction is exactly EBREAK
//   writes_rd_o        out : retiring this instruction writes the register file
// ----------------------------------------------------------------------------
module seq_decode
   import core_seq_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic        is_mul_o,
   output logic        is_halt_o,
   output logic        writes_rd_o
);

   logic [6:0] opcode;
   logic [6:0] funct7;
   logic [4:0] rd;

   assign opcode = instr_i[6:0];
   assign funct7 = instr_i[31:25];
   assign rd     = instr_i[11:7];

   always_comb begin
      is_halt_o   = (instr_i == INSTR_EBREAK);
      is_mul_o    = (opcode == OP_RTYPE) && (funct7 == FUNCT7_MULDIV);
      // Stores and branches have no destination; writes to x0 are dropped
      // so the register file never sees a pointless write strobe.
      writes_rd_o = (opcode != OP_STORE) && (opcode != OP_BRANCH) && (rd != 5'd0);
   end

endmodule : seq_decode

// File: rtl/core_sequencer.sv
// ----------------------------------------------------------------------------
// core_sequencer
// Multi-cycle control FSM that sequences the single-cycle core datapath:
// fetches an instruction over a req/ack memory port, latches it, classifies
// it, and issues one-cycle retire strobes (pc_en, rf_we). M-extension ops
// start the external multiplier and hold the PC until mul_done.
//
// Parameters:
//   MEM_TIMEOUT : max FETCH cycles without imem_ack before FAULT (1..255)
//   CNT_W       : width of the fetch-wait counter (must hold MEM_TIMEOUT)
//
// Ports:
//   clk          in        core clock, rising edge
//   rst          in        synchronous reset, active-high
//   run          in        1 = sequencer may start new instructions
//   imem_req     out       fetch request, held until imem_ack
//   imem_ack     in        one-cycle acknowledge, imem_rdata valid same cycle
//   imem_rdata   in  [31:0] fetched instruction word
//   instr        out [31:0] latched current instruction
//   instr_valid  out       instr holds a decoded, unretired instruction
//   pc_en        out       one-cycle PC advance strobe
//   rf_we        out       one-cycle register-file write strobe
//   mul_start    out       one-cycle multiplier start pulse
//   mul_done     in        multiplier result valid
//   halted       out       sequencer is in HALT
//   fault        out       sequencer is in FAULT (fetch timeout)
//
// Optional build macro SEQ_PERF_CNT_EN adds:
//   cyc_cnt      out [31:0] cycles spent outside IDLE/HALT/FAULT
//   ret_cnt      out [31:0] retired instructions (pc_en count)
// ----------------------------------------------------------------------------
module core_sequencer
   import core_seq_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 8
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        pc_en,
   output logic        rf_we,
   output logic        mul_start,
   input  logic        mul_done,
   output logic        halted,
   output logic        fault
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [31:0] cyc_cnt,
   output logic [31:0] ret_cnt
`endif
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

   seq_state_e       state_q, state_d;
   logic [31:0]      instr_q, instr_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0] wait_cnt_inc;

   logic is_mul;
   logic is_halt;
   logic writes_rd;

   seq_decode u_decode (
      .instr_i     (instr_q),
      .is_mul_o    (is_mul),
      .is_halt_o   (is_halt),
      .writes_rd_o (writes_rd)
   );

   assign wait_cnt_inc = wait_cnt_q + CNT_W'(1);
   assign instr        = instr_q;

   // State and instruction registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         instr_q    <= '0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      wait_cnt_d  = wait_cnt_q;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      pc_en       = 1'b0;
      rf_we       = 1'b0;
      mul_start   = 1'b0;
      halted      = 1'b0;
      fault       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d = ST_FETCH;
            end
         end

         ST_FETCH: begin
            imem_req = 1'b1;
            // Ack is checked first so a late ack on the final allowed
            // cycle still wins over the timeout.
            if (imem_ack) begin
               instr_d    = imem_rdata;
               wait_cnt_d = '0;
               state_d    = ST_DECODE;
            end else begin
               wait_cnt_d = wait_cnt_inc;
               if (wait_cnt_inc == TIMEOUT_C) begin
                  state_d = ST_FAULT;
               end
            end
         end

         ST_DECODE: begin
            instr_valid = 1'b1;
            if (is_halt) begin
               state_d = ST_HALT;
            end else if (is_mul) begin
               mul_start = 1'b1;
               state_d   = ST_MUL_WAIT;
            end else begin
               state_d = ST_EXEC;
            end
         end

         ST_EXEC: begin
            instr_valid = 1'b1;
            pc_en       = 1'b1;
            rf_we       = writes_rd;
            state_d     = run ? ST_FETCH : ST_IDLE;
         end

         // mul_done is only looked at here, so a done raised during the
         // DECODE cycle (same cycle as mul_start) cannot retire the op.
         ST_MUL_WAIT: begin
            instr_valid = 1'b1;
            if (mul_done) begin
               pc_en   = 1'b1;
               rf_we   = writes_rd;
               state_d = run ? ST_FETCH : ST_IDLE;
            end
         end

         ST_HALT: begin
            halted = 1'b1;
         end

         ST_FAULT: begin
            fault = 1'b1;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] cyc_cnt_q;
   logic [31:0] ret_cnt_q;
   logic        active;

   assign active = (state_q != ST_IDLE) && (state_q != ST_HALT) && (state_q != ST_FAULT);

   // Performance counters; both wrap naturally at 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_cnt_q <= '0;
         ret_cnt_q <= '0;
      end else begin
         if (active) begin
            cyc_cnt_q <= cyc_cnt_q + 32'd1;
         end
         if (pc_en) begin
            ret_cnt_q <= ret_cnt_q + 32'd1;
         end
      end
   end

   assign cyc_cnt = cyc_cnt_q;
   assign ret_cnt = ret_cnt_q;
`else
   // Performance counters not built.
`endif

endmodule : core_sequencer

// File: tb/tb_core_sequencer.sv
// ----------------------------------------------------------------------------
// tb_core_sequencer
// Directed testbench for core_sequencer. Status vector bit order:
//   {imem_req, instr_valid, pc_en, rf_we, mul_start, halted, fault}
// ----------------------------------------------------------------------------
module tb_core_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        imem_req;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic        pc_en;
   logic        rf_we;
   logic        mul_start;
   logic        mul_done;
   logic        halted;
   logic        fault;
`ifdef SEQ_PERF_CNT_EN
   logic [31:0] cyc_cnt;
   logic [31:0] ret_cnt;
`endif

   logic [6:0] st;
   assign st = {imem_req, instr_valid, pc_en, rf_we, mul_start, halted, fault};

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [31:0] I_ADDI   = 32'h00500093;
   localparam logic [31:0] I_STORE  = 32'h0020A023;
   localparam logic [31:0] I_MUL    = 32'h022081B3;
   localparam logic [31:0] I_EBREAK = 32'h00100073;

   core_sequencer #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .imem_req    (imem_req),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc_en       (pc_en),
      .rf_we       (rf_we),
      .mul_start   (mul_start),
      .mul_done    (mul_done),
      .halted      (halted),
      .fault       (fault)
`ifdef SEQ_PERF_CNT_EN
      ,
      .cyc_cnt     (cyc_cnt),
      .ret_cnt     (ret_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      run        = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      mul_done   = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (st !== 7'b0000000) begin
         n_errors++; $display("FAIL reset_status: got %b expected %b", st, 7'b0000000);
      end
      n_checks++;
      if (instr !== 32'h0) begin
         n_errors++; $display("FAIL reset_instr: got %h expected %h", instr, 32'h0);
      end
   endtask

   task automatic test_addi();
      do_reset();
      run = 1'b1;
      tick();                               // FETCH
      n_checks++;
      if (st !== 7'b1000000) begin
         n_errors++; $display("FAIL addi_fetch: got %b expected %b", st, 7'b1000000);
      end
      imem_ack = 1'b1; imem_rdata = I_ADDI;
      tick();                               // DECODE
      imem_ack = 1'b0; imem_rdata = 32'hDEADBEEF;
      #1;
      n_checks++;
      if (st !== 7'b0100000) begin
         n_errors++; $display("FAIL addi_decode: got %b expected %b", st, 7'b0100000);
      end
      n_checks++;
      if (instr !== I_ADDI) begin
         n_errors++; $display("FAIL addi_instr: got %h expected %h", instr, I_ADDI);
      end
      tick();                               // EXEC
      n_checks++;
      if (st !== 7'b0111000) begin
         n_errors++; $display("FAIL addi_exec: got %b expected %b", st, 7'b0111000);
      end
      tick();                               // back to FETCH, strobes drop
      n_checks++;
      if (st !== 7'b1000000) begin
         n_errors++; $display("FAIL addi_next_fetch: got %b expected %b", st, 7'b1000000);
      end
   endtask

   // Runs from the FETCH state left by test_addi
   task automatic test_store();
      imem_ack = 1'b1; imem_rdata = I_STORE;
      tick();
      imem_ack = 1'b0;
      #1;
      n_checks++;
      if (st !== 7'b0100000) begin
         n_errors++; $display("FAIL store_decode: got %b expected %b", st, 7'b0100000);
      end
      tick();
      n_checks++;
      if (st !== 7'b0110000) begin
         n_errors++; $display("FAIL store_exec: got %b expected %b", st, 7'b0110000);
      end
      tick();
      n_checks++;
      if (st !== 7'b1000000) begin
         n_errors++; $display("FAIL store_next_fetch: got %b expected %b", st, 7'b1000000);
      end
   endtask

   // Runs from the FETCH state left by test_store
   task automatic test_mul();
      imem_ack = 1'b1; imem_rdata = I_MUL;
      tick();                               // DECODE
      imem_ack = 1'b0;
      #1;
      n_checks++;
      if (st !== 7'b0100100) begin
         n_errors++; $display("FAIL mul_decode: got %b expected %b", st, 7'b0100100);
      end
      mul_done = 1'b1;                      // same cycle as mul_start: ignored
      tick();                               // MUL_WAIT cycle 1
      mul_done = 1'b0;
      #1;
      n_checks++;
      if (st !== 7'b0100000) begin
         n_errors++; $display("FAIL mul_early_done: got %b expected %b", st, 7'b0100000);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (st !== 7'b0100000) begin
            n_errors++; $display("FAIL mul_wait%0d: got %b expected %b", i, st, 7'b0100000);
         end
      end
      tick();                               // MUL_WAIT cycle 5
      mul_done = 1'b1;
      #1;
      n_checks++;
      if (st !== 7'b0111000) begin
         n_errors++; $display("FAIL mul_retire: got %b expected %b", st, 7'b0111000);
      end
      tick();
      mul_done = 1'b0;
      #1;
      n_checks++;
      if (st !== 7'b1000000) begin
         n_errors++; $display("FAIL mul_next_fetch: got %b expected %b", st, 7'b1000000);
      end
   endtask

   task automatic test_run_drop();
      do_reset();
      run = 1'b1;
      tick();                               // FETCH
      run = 1'b0;
      imem_ack = 1'b1; imem_rdata = I_ADDI;
      tick();                               // DECODE
      imem_ack = 1'b0;
      #1;
      n_checks++;
      if (st !== 7'b0100000) begin
         n_errors++; $display("FAIL rundrop_decode: got %b expected %b", st, 7'b0100000);
      end
      tick();
      n_checks++;
      if (st !== 7'b0111000) begin
         n_errors++; $display("FAIL rundrop_exec: got %b expected %b", st, 7'b0111000);
      end
      tick();
      n_checks++;
      if (st !== 7'b0000000) begin
         n_errors++; $display("FAIL rundrop_idle: got %b expected %b", st, 7'b0000000);
      end
      tick();
      n_checks++;
      if (st !== 7'b0000000) begin
         n_errors++; $display("FAIL rundrop_stay_idle: got %b expected %b", st, 7'b0000000);
      end
`ifdef SEQ_PERF_CNT_EN
      n_checks++;
      if (ret_cnt !== 32'd1) begin
         n_errors++; $display("FAIL rundrop_ret_cnt: got %0d expected %0d", ret_cnt, 1);
      end
      n_checks++;
      if (cyc_cnt !== 32'd3) begin
         n_errors++; $display("FAIL rundrop_cyc_cnt: got %0d expected %0d", cyc_cnt, 3);
      end
`endif
   endtask

   task automatic test_ebreak();
      do_reset();
      run = 1'b1;
      tick();
      imem_ack = 1'b1; imem_rdata = I_EBREAK;
      tick();                               // DECODE
      imem_ack = 1'b0;
      #1;
      n_checks++;
      if (st !== 7'b0100000) begin
         n_errors++; $display("FAIL ebreak_decode: got %b expected %b", st, 7'b0100000);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if (st !== 7'b0000010) begin
            n_errors++; $display("FAIL ebreak_halt%0d: got %b expected %b", i, st, 7'b0000010);
         end
      end
`ifdef SEQ_PERF_CNT_EN
      n_checks++;
      if (ret_cnt !== 32'd0) begin
         n_errors++; $display("FAIL ebreak_ret_cnt: got %0d expected %0d", ret_cnt, 0);
      end
`endif
   endtask

   task automatic test_timeout();
      do_reset();
      run = 1'b1;
      tick();                               // FETCH cycle 1
      for (int i = 0; i < 14; i++) tick();  // FETCH cycle 15
      n_checks++;
      if (st !== 7'b1000000) begin
         n_errors++; $display("FAIL timeout_last_fetch: got %b expected %b", st, 7'b1000000);
      end
      tick();
      n_checks++;
      if (st !== 7'b0000001) begin
         n_errors++; $display("FAIL timeout_fault: got %b expected %b", st, 7'b0000001);
      end
      imem_ack = 1'b1; imem_rdata = I_ADDI;
      tick();
      imem_ack = 1'b0;
      tick();
      n_checks++;
      if (st !== 7'b0000001) begin
         n_errors++; $display("FAIL timeout_sticky: got %b expected %b", st, 7'b0000001);
      end
      do_reset();
      n_checks++;
      if (st !== 7'b0000000) begin
         n_errors++; $display("FAIL timeout_cleared: got %b expected %b", st, 7'b0000000);
      end
   endtask

   task automatic test_ack_wins();
      do_reset();
      run = 1'b1;
      tick();
      for (int i = 0; i < 14; i++) tick();  // FETCH cycle 15
      imem_ack = 1'b1; imem_rdata = I_ADDI;
      tick();
      imem_ack = 1'b0;
      #1;
      n_checks++;
      if (st !== 7'b0100000) begin
         n_errors++; $display("FAIL ackwins_decode: got %b expected %b", st, 7'b0100000);
      end
   endtask

   task automatic test_rst_mid_mul();
      do_reset();
      run = 1'b1;
      tick();
      imem_ack = 1'b1; imem_rdata = I_MUL;
      tick();                               // DECODE
      imem_ack = 1'b0;
      tick();                               // MUL_WAIT
      n_checks++;
      if (st !== 7'b0100000) begin
         n_errors++; $display("FAIL rstmul_wait: got %b expected %b", st, 7'b0100000);
      end
      rst = 1'b1; mul_done = 1'b1;
      tick();
      n_checks++;
      if (st !== 7'b0000000) begin
         n_errors++; $display("FAIL rstmul_idle: got %b expected %b", st, 7'b0000000);
      end
      n_checks++;
      if (instr !== 32'h0) begin
         n_errors++; $display("FAIL rstmul_instr: got %h expected %h", instr, 32'h0);
      end
      rst = 1'b0; mul_done = 1'b0;
      tick();
      n_checks++;
      if (st !== 7'b1000000) begin
         n_errors++; $display("FAIL rstmul_restart: got %b expected %b", st, 7'b1000000);
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_store();
      test_mul();
      test_run_drop();
      test_ebreak();
      test_timeout();
      test_ack_wins();
      test_rst_mid_mul();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_core_sequencer

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM that sequences the single-cycle core datapath.
- Handshakes instruction fetch with instruction memory and latches the fetched word.
- Decodes the opcode class and issues one-cycle `pc_en` and `rf_we` strobes on retire.
- Holds the PC while the 32-bit multiplier runs.
- Sits between the instruction memory port and the datapath enable and control inputs.

Parameters:
MEM_TIMEOUT, 15, max cycles FETCH waits for imem_ack before FAULT (1..255)
CNT_W, 8, width of the fetch-wait counter (must hold MEM_TIMEOUT)

Ports:
clk  input  1  core clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
run  input  1  level; 1 = sequencer may start new instructions
imem_req  output  1  fetch request, held until imem_ack
imem_ack  input  1  one-cycle acknowledge; imem_rdata valid same cycle
imem_rdata  input  32  fetched instruction word
instr  output  32  latched current instruction
instr_valid  output  1  1 while instr holds a decoded, unretired instruction
pc_en  output  1  one-cycle strobe: PC register advances
rf_we  output  1  one-cycle register-file write strobe
mul_start  output  1  one-cycle multiplier start pulse
mul_done  input  1  multiplier result valid (level or pulse)
halted  output  1  1 in HALT state
fault  output  1  1 in FAULT state (fetch timeout)

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MUL_WAIT, HALT, FAULT.
- Encoding lives in the package.

Reset:
- Synchronous reset → IDLE. instr=0, wait counter=0.
- All outputs 0.
- rst overrides every state, including mid-fetch and MUL_WAIT. Any pending ack or mul_done is ignored.

State transitions:
- IDLE: run=1 → FETCH next cycle. Otherwise stay.
- FETCH:
  - imem_req=1; counter increments each cycle without ack.
  - imem_ack=1 → instr←imem_rdata, counter←0, → DECODE.
  - counter reaches MEM_TIMEOUT without ack → FAULT, imem_req drops.
  - If ack arrives on the same cycle the counter hits MEM_TIMEOUT, the ack wins.
- DECODE (1 cycle), instr_valid=1, opcode=instr[6:0]:
  - instr==32'h00100073 (EBREAK) → HALT; no pc_en, no rf_we.
  - opcode==7'b0110011 and instr[31:25]==7'b0000001 (M-ext) → mul_start=1 this cycle, → MUL_WAIT.
  - else → EXEC.
- EXEC (1 cycle):
  - pc_en=1.
  - rf_we=1 unless opcode is 7'b0100011 (STORE) or 7'b1100011 (BRANCH), or instr[11:7]==0.
  - Next state: FETCH if run=1, else IDLE.
- MUL_WAIT:
  - Hold; pc_en=0.
  - mul_done=1 → same retire strobes as EXEC in that cycle.
  - Next state: FETCH if run, else IDLE.
  - mul_done seen in the same cycle as mul_start is ignored.
- HALT, FAULT: sticky until rst; all strobes 0.

Run and strobe rules:
- Deasserting run mid-instruction does not abort it. The current instruction retires, then the FSM goes to IDLE.
- instr_valid=1 in DECODE, EXEC and MUL_WAIT; 0 elsewhere.
- pc_en and rf_we are never asserted for more than one consecutive cycle per instruction.

Latency:
- Minimum 3 cycles per non-mul instruction with ack in the first FETCH cycle: FETCH, DECODE, EXEC.

Optional Feature:
Macro: SEQ_PERF_CNT_EN.
- Defined:
  - Adds outputs `cyc_cnt[31:0]` and `ret_cnt[31:0]`, both reset to 0.
  - cyc_cnt increments every cycle not in IDLE, HALT or FAULT.
  - ret_cnt increments on every pc_en.
  - Both wrap from 32'hFFFFFFFF to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package `core_seq_pkg`:
  - state enum;
  - opcode constants OP_RTYPE, OP_STORE, OP_BRANCH;
  - FUNCT7_MULDIV;
  - INSTR_EBREAK.
- One sub-module: `seq_decode`, purely combinational. Takes instr; outputs is_mul, is_halt, writes_rd.

Test Plan:
- rst held 2 cycles, run=1, ack in the first FETCH cycle, instr=32'h00500093 (addi x1,x0,5) → pc_en and rf_we each high exactly 1 cycle, 3 cycles after leaving IDLE.
- STORE 32'h0020A023 → pc_en=1, rf_we=0 in EXEC.
- MUL 32'h022081B3, mul_done after 5 cycles → mul_start 1 pulse in DECODE; pc_en=0 during wait; pc_en and rf_we pulse with mul_done.
- No imem_ack for MEM_TIMEOUT=15 cycles → fault=1, imem_req=0; stays in FAULT until rst.
- EBREAK 32'h00100073 → halted=1, pc_en never asserted. rst asserted mid-MUL_WAIT → IDLE next cycle, all outputs 0.
- run dropped during FETCH → instruction completes, then IDLE with imem_req=0. With SEQ_PERF_CNT_EN defined, ret_cnt=1.
